// File: rtl/stutter_sync_scheduler.sv
// -----------------------------------------------------------------------------
// stutter_sync_scheduler
//
// Keeps two codeblock instances (source A, target B) in lock-step on their
// observable steps, which are the cycles where public_out updates. An instance
// that reaches an observable step first is parked via its stutter input until
// the other instance catches up. The pair then steps together. One cycle later
// the two public outputs are compared.
//
// The block flags three conditions, each sticky until reset:
//   - value mismatches,
//   - unmatched observations (the partner terminated instead),
//   - holds longer than MAX_WAIT cycles.
// It also reports when both instances have terminated.
//
// Ports
//   clk         in   1       clock, rising edge
//   rst_n       in   1       synchronous active-low reset
//   sched_en    in   1       0: stall both instances, freeze FSM and wait count
//   obs_next_a  in   1       A's next step updates its public_out
//   obs_next_b  in   1       B's next step updates its public_out
//   done_a      in   1       A is in its terminal state
//   done_b      in   1       B is in its terminal state
//   pub_a       in   DATA_W  A's public_out
//   pub_b       in   DATA_W  B's public_out
//   stutter_a   out  1       A's stutter_in (combinational)
//   stutter_b   out  1       B's stutter_in (combinational)
//   match_cnt   out  CNT_W   count of equal paired observations, saturating
//   mismatch    out  1       sticky value mismatch / unmatched observation
//   timeout     out  1       sticky hold timeout
//   all_done    out  1       both instances terminated
// -----------------------------------------------------------------------------
module stutter_sync_scheduler #(
  parameter int DATA_W   = 2,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 12,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_en,
  input  logic              obs_next_a,
  input  logic              obs_next_b,
  input  logic              done_a,
  input  logic              done_b,
  input  logic [DATA_W-1:0] pub_a,
  input  logic [DATA_W-1:0] pub_b,
  output logic              stutter_a,
  output logic              stutter_b,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              mismatch,
  output logic              timeout,
  output logic              all_done
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    HOLD_A = 3'd1,
    HOLD_B = 3'd2,
    FAULT  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t             state_q,     state_d;
  logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
  logic               cmp_pend_q,  cmp_pend_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               mismatch_q,  mismatch_d;
  logic               timeout_q,   timeout_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned; that keeps this block free of inferred latches.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cmp_pend_d  = 1'b0;
    match_cnt_d = match_cnt_q;
    mismatch_d  = mismatch_q;
    timeout_d   = timeout_q;
    stutter_a   = 1'b1;
    stutter_b   = 1'b1;

    // A pending compare resolves in every state, stalled or not. It sees the
    // public outputs produced by the previous cycle's paired step.
    if (cmp_pend_q) begin
      if (pub_a == pub_b) begin
        if (match_cnt_q != {CNT_W{1'b1}}) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
        end
      end else begin
        mismatch_d = 1'b1;
      end
    end

    // While reset is asserted, both instances stay parked. All defaults
    // already hold both stutters at 1.
    if (rst_n && sched_en) begin
      unique case (state_q)
        RUN: begin
          if (done_a && done_b) begin
            state_d = DONE;
          end else if (done_a) begin
            // A has terminated, so any observation B makes has no partner.
            stutter_b = 1'b0;
            if (obs_next_b) mismatch_d = 1'b1;
          end else if (done_b) begin
            stutter_a = 1'b0;
            if (obs_next_a) mismatch_d = 1'b1;
          end else if (obs_next_a && obs_next_b) begin
            stutter_a  = 1'b0;
            stutter_b  = 1'b0;
            cmp_pend_d = 1'b1;
          end else if (obs_next_a) begin
            // Park A on its observable step and let B catch up.
            stutter_b  = 1'b0;
            state_d    = HOLD_A;
            wait_cnt_d = '0;
          end else if (obs_next_b) begin
            stutter_a  = 1'b0;
            state_d    = HOLD_B;
            wait_cnt_d = '0;
          end else begin
            stutter_a = 1'b0;
            stutter_b = 1'b0;
          end
        end

        HOLD_A: begin
          if (obs_next_b) begin
            stutter_a  = 1'b0;
            stutter_b  = 1'b0;
            cmp_pend_d = 1'b1;
            state_d    = RUN;
          end else if (done_b) begin
            // B terminated without matching A's observation. Release A on its own.
            mismatch_d = 1'b1;
            stutter_a  = 1'b0;
            state_d    = RUN;
          end else begin
            stutter_b = 1'b0;
            if (wait_cnt_q == WAIT_LAST) begin
              timeout_d = 1'b1;
              state_d   = FAULT;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end

        HOLD_B: begin
          if (obs_next_a) begin
            stutter_a  = 1'b0;
            stutter_b  = 1'b0;
            cmp_pend_d = 1'b1;
            state_d    = RUN;
          end else if (done_a) begin
            mismatch_d = 1'b1;
            stutter_b  = 1'b0;
            state_d    = RUN;
          end else begin
            stutter_a = 1'b0;
            if (wait_cnt_q == WAIT_LAST) begin
              timeout_d = 1'b1;
              state_d   = FAULT;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end

        // FAULT and DONE are terminal until reset. Both instances stay parked.
        FAULT, DONE: ;

        default: state_d = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      cmp_pend_q  <= 1'b0;
      match_cnt_q <= '0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before the edge, regardless of statement order.
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cmp_pend_q  <= cmp_pend_d;
      match_cnt_q <= match_cnt_d;
      mismatch_q  <= mismatch_d;
      timeout_q   <= timeout_d;
    end
  end

  assign match_cnt = match_cnt_q;
  assign mismatch  = mismatch_q;
  assign timeout   = timeout_q;
  assign all_done  = (state_q == DONE);

endmodule
